// File: rtl/data_bus_xbar.sv
`default_nettype none
// ============================================================================
// data_bus_xbar : core data port to N base/mask-decoded slaves, single outstanding
// Revision      : 1.0
// ============================================================================
module data_bus_xbar #(
  parameter int N_SLAVES = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE =
    {32'h8000_2000, 32'h8000_1000, 32'h8000_0000, 32'h0000_0000},
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK =
    {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_FF00},
  parameter int TIMEOUT  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       m_req_i,
  input  logic                       m_we_i,
  input  logic [DATA_W/8-1:0]        m_be_i,
  input  logic [ADDR_W-1:0]          m_addr_i,
  input  logic [DATA_W-1:0]          m_wdata_i,
  output logic                       m_gnt_o,
  output logic                       m_rvalid_o,
  output logic [DATA_W-1:0]          m_rdata_o,
  output logic                       m_err_o,
  output logic [N_SLAVES-1:0]        s_req_o,
  output logic                       s_we_o,
  output logic [DATA_W/8-1:0]        s_be_o,
  output logic [ADDR_W-1:0]          s_addr_o,
  output logic [DATA_W-1:0]          s_wdata_o,
  input  logic [N_SLAVES-1:0]        s_gnt_i,
  input  logic [N_SLAVES-1:0]        s_rvalid_i,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata_i,
  output logic [ADDR_W-1:0]          err_addr_o,
  output logic [7:0]                 err_cnt_o
);

  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RESP = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [SEL_W-1:0]    r_sel;
  logic [TMR_W-1:0]    r_timer;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_err_addr;
  logic [7:0]          r_err_cnt;

  logic                w_hit;
  logic [SEL_W-1:0]    w_idx;
  logic                w_accept;
  logic                w_unmapped;
  logic                w_timeout;
  logic                w_sel_rvalid;
  logic [DATA_W-1:0]   w_rdata_arr [N_SLAVES];

  for (genvar k = 0; k < N_SLAVES; k++) begin : g_rdata_slice
    assign w_rdata_arr[k] = s_rdata_i[k*DATA_W +: DATA_W];
  end

  // Descending scan so the lowest matching window overrides higher ones.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int k = N_SLAVES - 1; k >= 0; k--) begin
      if ((m_addr_i & SLV_MASK[k*ADDR_W +: ADDR_W]) == SLV_BASE[k*ADDR_W +: ADDR_W]) begin
        w_hit = 1'b1;
        w_idx = SEL_W'(k);
      end
    end
  end

  assign w_sel_rvalid = s_rvalid_i[r_sel];

  assign s_we_o    = rst_n_i ? m_we_i    : 1'b0;
  assign s_be_o    = rst_n_i ? m_be_i    : '0;
  assign s_addr_o  = rst_n_i ? m_addr_i  : '0;
  assign s_wdata_o = rst_n_i ? m_wdata_i : '0;
  assign err_addr_o = r_err_addr;
  assign err_cnt_o  = r_err_cnt;

  always_comb begin
    w_state_nxt = r_state;
    s_req_o     = '0;
    m_gnt_o     = 1'b0;
    m_rvalid_o  = 1'b0;
    m_err_o     = 1'b0;
    m_rdata_o   = '0;
    w_accept    = 1'b0;
    w_unmapped  = 1'b0;
    w_timeout   = 1'b0;
    if (rst_n_i) begin
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            s_req_o[w_idx] = m_req_i;
            m_gnt_o        = s_gnt_i[w_idx];
            if (m_req_i && s_gnt_i[w_idx]) begin
              w_accept    = 1'b1;
              w_state_nxt = S_RESP;
            end
          end else begin
            m_gnt_o = m_req_i;
            if (m_req_i) begin
              w_unmapped  = 1'b1;
              w_state_nxt = S_ERR;
            end
          end
        end
        S_RESP: begin
          if (w_sel_rvalid) begin
            m_rvalid_o  = 1'b1;
            m_rdata_o   = w_rdata_arr[r_sel];
            w_state_nxt = S_IDLE;
          end else if (r_timer == c_tmr_last) begin
            m_rvalid_o  = 1'b1;
            m_err_o     = 1'b1;
            w_timeout   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_ERR: begin
          m_rvalid_o  = 1'b1;
          m_err_o     = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_timer    <= '0;
      r_addr     <= '0;
      r_err_addr <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_sel   <= w_idx;
        r_timer <= '0;
        r_addr  <= m_addr_i;
      end else if (r_state == S_RESP && !w_sel_rvalid && !w_timeout) begin
        r_timer <= r_timer + TMR_W'(1);
      end
      if (w_unmapped)
        r_err_addr <= m_addr_i;
      else if (w_timeout)
        r_err_addr <= r_addr;
      if ((w_timeout || r_state == S_ERR) && r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_bus_xbar.sv
`default_nettype none
// ============================================================================
// tb_data_bus_xbar : randomized transaction-level check of data_bus_xbar
// Revision         : 1.0
// ============================================================================
module tb_data_bus_xbar;

  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         m_req, m_we;
  logic [3:0]   m_be;
  logic [31:0]  m_addr, m_wdata;
  logic         m_gnt, m_rvalid, m_err;
  logic [31:0]  m_rdata;
  logic [3:0]   s_req;
  logic         s_we;
  logic [3:0]   s_be;
  logic [31:0]  s_addr, s_wdata;
  logic [3:0]   s_gnt, s_rvalid;
  logic [127:0] s_rdata;
  logic [31:0]  err_addr;
  logic [7:0]   err_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int exp_cnt = 0;
  logic [31:0] exp_eaddr = '0;

  logic [31:0] base_a [4] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_1000, 32'h8000_2000};
  logic [31:0] mask_a [4] = '{32'hFFFF_FF00, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};

  data_bus_xbar #(
    .N_SLAVES(4), .DATA_W(32), .ADDR_W(32),
    .SLV_BASE({32'h8000_2000, 32'h8000_1000, 32'h8000_0000, 32'h0000_0000}),
    .SLV_MASK({32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_FF00}),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_req_i(m_req), .m_we_i(m_we), .m_be_i(m_be), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata), .m_err_o(m_err),
    .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .err_addr_o(err_addr), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < 4; k++)
      if ((a & mask_a[k]) == base_a[k]) return k;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_err(input logic [31:0] a);
    exp_eaddr = a;
    exp_cnt   = (exp_cnt < 255) ? exp_cnt + 1 : 255;
  endtask

  // One full master transaction; slave timing given by gd (grant delay) and rd (response delay).
  task automatic do_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                        input logic [31:0] wd, input int gd, input int rd,
                        input logic [31:0] rdat, input logic stray);
    int k, j, last;
    logic hold;
    k = decode(addr);
    hold = 1'($urandom % 2);
    m_req = 1'b1; m_we = we; m_be = be; m_addr = addr; m_wdata = wd;
    s_gnt = '0; s_rvalid = '0;
    if (k < 0) s_gnt = 4'($urandom);
    #2;
    check_val("bc_addr", s_addr, addr);
    check_val("bc_be", 32'(s_be), 32'(be));
    check_val("bc_we", 32'(s_we), 32'(we));
    check_val("bc_wdata", s_wdata, wd);
    if (k < 0) begin
      check_val("unm_gnt", 32'(m_gnt), 1);
      check_val("unm_sreq", 32'(s_req), 0);
      check_val("unm_rv0", 32'(m_rvalid), 0);
      tick();
      #2;
      check_val("err_rv", 32'(m_rvalid), 1);
      check_val("err_flag", 32'(m_err), 1);
      check_val("err_rdata", m_rdata, 0);
      check_val("err_gnt", 32'(m_gnt), 0);
      m_req = 1'b0;
      tick();
      bump_err(addr);
    end else begin
      for (int i = 0; i < gd; i++) begin
        check_val("wait_gnt", 32'(m_gnt), 0);
        check_val("wait_sreq", 32'(s_req), 32'(1 << k));
        check_val("wait_rv", 32'(m_rvalid), 0);
        tick();
        #2;
      end
      s_gnt = 4'(1 << k);
      #1;
      check_val("gnt", 32'(m_gnt), 1);
      check_val("sreq", 32'(s_req), 32'(1 << k));
      tick();
      if (!hold) m_req = 1'b0;
      s_gnt = hold ? 4'hF : 4'h0;
      last = (rd < TIMEOUT) ? rd : TIMEOUT - 1;
      for (int c = 0; c <= last; c++) begin
        if (c == last) begin m_req = 1'b0; s_gnt = '0; end
        if (c == rd) begin
          s_rvalid[k] = 1'b1;
          s_rdata[k*32 +: 32] = rdat;
        end
        if (stray) begin
          j = (k + 1 + int'($urandom % 3)) % 4;
          s_rvalid[j] = 1'b1;
          s_rdata[j*32 +: 32] = $urandom;
        end
        #2;
        check_val("resp_gnt", 32'(m_gnt), 0);
        check_val("resp_sreq", 32'(s_req), 0);
        if (c == rd) begin
          check_val("rsp_rv", 32'(m_rvalid), 1);
          check_val("rsp_err", 32'(m_err), 0);
          check_val("rsp_rdata", m_rdata, rdat);
        end else if (c == last) begin
          check_val("to_rv", 32'(m_rvalid), 1);
          check_val("to_err", 32'(m_err), 1);
          check_val("to_rdata", m_rdata, 0);
          bump_err(addr);
        end else begin
          check_val("busy_rv", 32'(m_rvalid), 0);
          check_val("busy_rdata", m_rdata, 0);
        end
        tick();
        s_rvalid = '0;
      end
    end
    s_gnt = '0;
    #2;
    check_val("err_cnt", 32'(err_cnt), 32'(exp_cnt));
    check_val("err_addr", err_addr, exp_eaddr);
  endtask

  function automatic logic [31:0] rand_addr(input int r);
    logic [31:0] a;
    if (r < 4) return base_a[r] | ($urandom & ~mask_a[r]);
    for (int t = 0; t < 20; t++) begin
      a = $urandom;
      if (decode(a) < 0) return a;
    end
    return 32'h4000_0000;
  endfunction

  initial begin
    rst_n = 1'b0; m_req = 0; m_we = 0; m_be = 0; m_addr = 32'h1234_5678; m_wdata = 0;
    s_gnt = 4'hF; s_rvalid = 4'hF; s_rdata = '1;
    #4;
    check_val("rst_gnt", 32'(m_gnt), 0);
    check_val("rst_rv", 32'(m_rvalid), 0);
    check_val("rst_addr", s_addr, 0);
    check_val("rst_cnt", 32'(err_cnt), 0);
    check_val("rst_eaddr", err_addr, 0);
    s_gnt = 0; s_rvalid = 0; s_rdata = '0;
    #13 rst_n = 1'b1;
    tick();

    do_txn(32'h0000_0010, 1'b0, 4'hF, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0);
    do_txn(32'h8000_0004, 1'b1, 4'b0011, 32'h1234, 0, 1, $urandom, 1'b0);
    do_txn(32'h4000_0000, 1'b0, 4'hF, 32'h0, 0, 0, 32'h0, 1'b0);
    do_txn(32'h8000_2008, 1'b0, 4'hF, 32'h0, 0, 1000, 32'h0, 1'b1);
    do_txn(32'h0000_0020, 1'b0, 4'hF, 32'h0, 3, 2, 32'hCAFE_F00D, 1'b0);

    // abort a transaction with reset while waiting for the response
    m_req = 1'b1; m_addr = 32'h8000_1010; s_gnt = 4'b0010;
    tick();
    m_req = 1'b0; s_gnt = '0;
    tick(); tick();
    s_rvalid = 4'b0010; s_rdata[63:32] = 32'h5555_AAAA;
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_rv", 32'(m_rvalid), 0);
    check_val("arst_rdata", m_rdata, 0);
    check_val("arst_cnt", 32'(err_cnt), 0);
    check_val("arst_eaddr", err_addr, 0);
    check_val("arst_saddr", s_addr, 0);
    exp_cnt = 0; exp_eaddr = '0;
    #4 rst_n = 1'b1;
    s_rvalid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      tick();
      #2 check_val("post_rst_rv", 32'(m_rvalid), 0);
    end
    s_rvalid = '0;

    for (int i = 0; i < 260; i++)
      do_txn(rand_addr(4), 1'($urandom), 4'($urandom), $urandom, 0, 0, 32'h0, 1'b0);
    check_val("sat_cnt", 32'(err_cnt), 255);

    for (int i = 0; i < 200; i++) begin
      int r, gd, rd;
      r  = int'($urandom % 5);
      gd = int'($urandom % 3);
      rd = ($urandom % 10 == 0) ? int'($urandom_range(0, TIMEOUT + 2)) : int'($urandom % 4);
      do_txn(rand_addr(r), 1'($urandom), 4'($urandom), $urandom, gd, rd, $urandom,
             1'($urandom % 4 == 0));
      s_rvalid = 4'($urandom);
      #2 check_val("idle_rv", 32'(m_rvalid), 0);
      tick();
      s_rvalid = '0;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
